// File: rtl/mem_access_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_lsu
// Description : Load/store memory-access stage sitting in front of the data
//               cache controller. Captures one load or store from execute,
//               aligns the address, builds a word-aligned store word with a
//               byte strobe, issues a single cache request, waits for the
//               response, then presents a sign/zero-extended load result.
// Revision    : 1.0 - initial release
//
// Optional    : MISALIGN_TRAP_EN - when defined, a misaligned access skips
//               the cache and pulses o_misalign. When undefined, o_misalign
//               is held at 0 and the access offset is forced to natural
//               alignment.
//
// Ports
//   i_clk, i_areset_n            clock, asynchronous active-low reset
//   i_valid/i_load/i_store       op handshake from execute
//   i_funct3, i_addr, i_wdata    access width/sign, byte address, store value
//   i_rd                         load destination register
//   o_stall                      hold execute
//   o_req, o_req_write, o_addr,
//   o_store_data, o_wstrb        cache request (held until i_req_ready)
//   i_req_ready                  cache accepts the request
//   i_data_valid, i_data         cache response
//   o_wb_valid, o_wb_rd,
//   o_wb_data                    one-cycle load writeback
//   o_misalign                   misaligned-access exception pulse
// ============================================================================
module mem_access_lsu #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int REG_BITS  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic                 i_valid,
    input  logic                 i_load,
    input  logic                 i_store,
    input  logic [2:0]           i_funct3,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [REG_BITS-1:0]  i_rd,
    output logic                 o_stall,
    output logic                 o_req,
    output logic                 o_req_write,
    output logic [ADDR_SIZE-1:0] o_addr,
    output logic [DATA_SIZE-1:0] o_store_data,
    output logic [3:0]           o_wstrb,
    input  logic                 i_req_ready,
    input  logic                 i_data_valid,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic                 o_wb_valid,
    output logic [REG_BITS-1:0]  o_wb_rd,
    output logic [DATA_SIZE-1:0] o_wb_data,
    output logic                 o_misalign
);

`ifdef MISALIGN_TRAP_EN
    localparam logic C_TRAP_EN = 1'b1;
`else
    localparam logic C_TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state_q,    w_state_d;
    logic [ADDR_SIZE-3:0]   r_waddr_q,    w_waddr_d;
    logic [2:0]             r_funct3_q,   w_funct3_d;
    logic [1:0]             r_off_q,      w_off_d;
    logic [REG_BITS-1:0]    r_rd_q,       w_rd_d;
    logic                   r_write_q,    w_write_d;
    logic [DATA_SIZE-1:0]   r_sdata_q,    w_sdata_d;
    logic [3:0]             r_wstrb_q,    w_wstrb_d;
    logic                   r_req_q,      w_req_d;
    logic                   r_wb_valid_q, w_wb_valid_d;
    logic [DATA_SIZE-1:0]   r_wb_data_q,  w_wb_data_d;
    logic                   r_misalign_q, w_misalign_d;

    // Capture-side decode of the live op
    logic                   w_accept;
    logic                   w_is_byte;
    logic                   w_is_half;
    logic                   w_misal;
    logic [1:0]             w_cap_off;
    logic [3:0]             w_cap_strb;
    logic [DATA_SIZE-1:0]   w_cap_data;

    // Response-side extraction
    logic [7:0]             w_ld_byte;
    logic [15:0]            w_ld_half;
    logic [DATA_SIZE-1:0]   w_ld_ext;

    assign w_accept = i_valid & (i_load | i_store);

    // Width decode: funct3[1:0] selects byte/half; everything else (including
    // the unsupported encodings) behaves as a full word.
    always_comb begin
        w_is_byte  = (i_funct3[1:0] == 2'b00);
        w_is_half  = (i_funct3[1:0] == 2'b01);
        w_misal    = 1'b0;
        w_cap_off  = 2'b00;
        w_cap_strb = 4'b1111;
        w_cap_data = i_wdata;
        if (w_is_byte) begin
            w_cap_off  = i_addr[1:0];
            w_cap_strb = 4'b0001 << i_addr[1:0];
            w_cap_data = {4{i_wdata[7:0]}};
        end else if (w_is_half) begin
            w_misal    = i_addr[0];
            // Low offset bit dropped: the half is forced onto its natural lane
            w_cap_off  = {i_addr[1], 1'b0};
            w_cap_strb = i_addr[1] ? 4'b1100 : 4'b0011;
            w_cap_data = {2{i_wdata[15:0]}};
        end else begin
            w_misal    = (i_addr[1:0] != 2'b00);
        end
    end

    // Load extraction always uses the captured offset/width, never the live
    // execute-stage inputs, which may already belong to the next op.
    always_comb begin
        case (r_off_q)
            2'd0:    w_ld_byte = i_data[7:0];
            2'd1:    w_ld_byte = i_data[15:8];
            2'd2:    w_ld_byte = i_data[23:16];
            default: w_ld_byte = i_data[31:24];
        endcase
        w_ld_half = r_off_q[1] ? i_data[31:16] : i_data[15:0];
        case (r_funct3_q)
            3'b000:  w_ld_ext = {{(DATA_SIZE-8){w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_ext = {{(DATA_SIZE-8){1'b0}}, w_ld_byte};
            3'b001:  w_ld_ext = {{(DATA_SIZE-16){w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_ext = {{(DATA_SIZE-16){1'b0}}, w_ld_half};
            default: w_ld_ext = i_data;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_d    = r_state_q;
        w_waddr_d    = r_waddr_q;
        w_funct3_d   = r_funct3_q;
        w_off_d      = r_off_q;
        w_rd_d       = r_rd_q;
        w_write_d    = r_write_q;
        w_sdata_d    = r_sdata_q;
        w_wstrb_d    = r_wstrb_q;
        w_wb_data_d  = r_wb_data_q;
        w_req_d      = 1'b0;
        w_wb_valid_d = 1'b0;
        w_misalign_d = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_waddr_d  = i_addr[ADDR_SIZE-1:2];
                    w_funct3_d = i_funct3;
                    w_off_d    = w_cap_off;
                    w_rd_d     = i_rd;
                    w_write_d  = i_store;
                    w_sdata_d  = w_cap_data;
                    w_wstrb_d  = w_cap_strb;
                    if (C_TRAP_EN && w_misal) begin
                        w_state_d    = S_DONE;
                        w_misalign_d = 1'b1;
                    end else begin
                        w_state_d = S_REQ;
                        w_req_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (i_req_ready) begin
                    w_state_d = S_RESP;
                end else begin
                    w_req_d   = 1'b1;
                end
            end
            S_RESP: begin
                if (i_data_valid) begin
                    w_state_d = S_DONE;
                    if (!r_write_q) begin
                        w_wb_valid_d = 1'b1;
                        w_wb_data_d  = w_ld_ext;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state_q    <= S_IDLE;
            r_waddr_q    <= '0;
            r_funct3_q   <= '0;
            r_off_q      <= '0;
            r_rd_q       <= '0;
            r_write_q    <= 1'b0;
            r_sdata_q    <= '0;
            r_wstrb_q    <= '0;
            r_req_q      <= 1'b0;
            r_wb_valid_q <= 1'b0;
            r_wb_data_q  <= '0;
            r_misalign_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_waddr_q    <= w_waddr_d;
            r_funct3_q   <= w_funct3_d;
            r_off_q      <= w_off_d;
            r_rd_q       <= w_rd_d;
            r_write_q    <= w_write_d;
            r_sdata_q    <= w_sdata_d;
            r_wstrb_q    <= w_wstrb_d;
            r_req_q      <= w_req_d;
            r_wb_valid_q <= w_wb_valid_d;
            r_wb_data_q  <= w_wb_data_d;
            r_misalign_q <= w_misalign_d;
        end
    end

    // Stall must rise in the capture cycle itself, so it combines state with
    // the live handshake.
    assign o_stall      = (r_state_q == S_REQ) || (r_state_q == S_RESP) ||
                          ((r_state_q == S_IDLE) && w_accept);
    assign o_req        = r_req_q;
    assign o_req_write  = r_write_q;
    assign o_addr       = {r_waddr_q, 2'b00};
    assign o_store_data = r_sdata_q;
    assign o_wstrb      = r_wstrb_q;
    assign o_wb_valid   = r_wb_valid_q;
    assign o_wb_rd      = r_rd_q;
    assign o_wb_data    = r_wb_data_q;
    assign o_misalign   = r_misalign_q;

`ifndef SYNTHESIS
    // The cache never answers a request it has not yet accepted.
    a_no_early_data: assert property (@(posedge i_clk) disable iff (!i_areset_n)
        (r_state_q == S_REQ) |-> !i_data_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_lsu
// Description : Directed self-checking bench for mem_access_lsu. A width/
//               offset model computes the expected request and writeback for
//               each op; a per-cycle compare process checks the DUT against
//               it, and the stimulus tasks check handshake timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_lsu;

    logic        i_clk;
    logic        i_areset_n;
    logic        i_valid;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [4:0]  i_rd;
    logic        o_stall;
    logic        o_req;
    logic        o_req_write;
    logic [31:0] o_addr;
    logic [31:0] o_store_data;
    logic [3:0]  o_wstrb;
    logic        i_req_ready;
    logic        i_data_valid;
    logic [31:0] i_data;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_misalign;

    mem_access_lsu #(
        .ADDR_SIZE (32),
        .DATA_SIZE (32),
        .REG_BITS  (5)
    ) u_dut (
        .i_clk        (i_clk),
        .i_areset_n   (i_areset_n),
        .i_valid      (i_valid),
        .i_load       (i_load),
        .i_store      (i_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_rd         (i_rd),
        .o_stall      (o_stall),
        .o_req        (o_req),
        .o_req_write  (o_req_write),
        .o_addr       (o_addr),
        .o_store_data (o_store_data),
        .o_wstrb      (o_wstrb),
        .i_req_ready  (i_req_ready),
        .i_data_valid (i_data_valid),
        .i_data       (i_data),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_misalign   (o_misalign)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int errors = 0;
    int checks = 0;

    // Model expectations for the op currently in flight
    logic [31:0] exp_addr;
    logic [31:0] exp_sdata;
    logic [3:0]  exp_strb;
    logic        exp_write;
    logic [31:0] exp_wb;
    logic [4:0]  exp_rd;
    logic        exp_trap;

    // Observations captured by the compare process
    int          req_cycles;
    int          wb_count;
    logic [31:0] last_req_addr;
    logic [31:0] last_req_data;
    logic [3:0]  last_req_strb;
    logic [31:0] last_wb_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int sz_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Access described as "size bytes at offset": request word, strobe,
    // replicated store data and the extended load value.
    task automatic set_model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic [4:0] rd);
        int          sz;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        sz  = sz_of(f3);
        off = int'(addr % 4);
        off = off - (off % sz);
`ifdef MISALIGN_TRAP_EN
        exp_trap = ((addr % sz) != 0);
`else
        exp_trap = 1'b0;
`endif
        exp_addr  = addr - (addr % 4);
        exp_write = !ld;
        exp_rd    = rd;
        exp_strb  = 4'(((1 << sz) - 1) << off);
        for (int b = 0; b < 4; b++) exp_sdata[8*b +: 8] = wdata[8*(b % sz) +: 8];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (rdata >> (8 * off)) & mask;
        if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~mask;
        exp_wb = v;
    endtask

    // Per-cycle comparison against the model
    always @(negedge i_clk) begin
        if (i_areset_n) begin
            if (o_req) begin
                req_cycles++;
                chk("req_addr", o_addr, exp_addr);
                chk("req_write", 32'(o_req_write), 32'(exp_write));
                chk("req_wstrb", 32'(o_wstrb), 32'(exp_strb));
                if (exp_write) chk("req_store_data", o_store_data, exp_sdata);
                last_req_addr = o_addr;
                last_req_data = o_store_data;
                last_req_strb = o_wstrb;
            end
            if (o_wb_valid) begin
                wb_count++;
                chk("wb_data", o_wb_data, exp_wb);
                chk("wb_rd", 32'(o_wb_rd), 32'(exp_rd));
                last_wb_data = o_wb_data;
            end
`ifndef MISALIGN_TRAP_EN
            chk("misalign_tied_low", 32'(o_misalign), 32'd0);
`endif
        end
    end

    // One op with a given ready delay (cycles in REQ before ready) and
    // response delay (idle cycles in RESP before data valid).
    // Entered and left at posedge+1.
    task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input int rdy_dly, input int rsp_dly);
        set_model(ld, f3, addr, wdata, rdata, rd);
        req_cycles = 0;
        wb_count   = 0;
        i_valid = 1'b1; i_load = ld; i_store = !ld;
        i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_rd = rd;
        @(negedge i_clk);
        chk("stall_capture", 32'(o_stall), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        i_addr = 32'hFFFF_FFFF; i_funct3 = 3'b111;
        if (exp_trap) begin
            @(negedge i_clk);
            chk("trap_misalign", 32'(o_misalign), 32'd1);
            chk("trap_no_req", 32'(o_req), 32'd0);
            chk("trap_no_wb", 32'(o_wb_valid), 32'd0);
            chk("trap_stall", 32'(o_stall), 32'd0);
            @(posedge i_clk); #1;
            @(negedge i_clk);
            chk("trap_pulse_end", 32'(o_misalign), 32'd0);
            @(posedge i_clk); #1;
            return;
        end
        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge i_clk);
            chk("req_wait_req", 32'(o_req), 32'd1);
            chk("req_wait_stall", 32'(o_stall), 32'd1);
            @(posedge i_clk); #1;
        end
        i_req_ready = 1'b1;
        @(negedge i_clk);
        chk("req_accept", 32'(o_req), 32'd1);
        @(posedge i_clk); #1;
        i_req_ready = 1'b0;
        for (int k = 0; k < rsp_dly; k++) begin
            @(negedge i_clk);
            chk("resp_wait_stall", 32'(o_stall), 32'd1);
            chk("resp_wait_wb", 32'(o_wb_valid), 32'd0);
            @(posedge i_clk); #1;
        end
        i_data_valid = 1'b1; i_data = rdata;
        @(negedge i_clk);
        chk("resp_req_low", 32'(o_req), 32'd0);
        chk("resp_stall", 32'(o_stall), 32'd1);
        @(posedge i_clk); #1;
        i_data_valid = 1'b0; i_data = 32'h0;
        @(negedge i_clk);
        chk("done_stall", 32'(o_stall), 32'd0);
        chk("done_wb_valid", 32'(o_wb_valid), 32'(ld));
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("idle_wb_low", 32'(o_wb_valid), 32'd0);
        chk("req_cycle_count", 32'(req_cycles), 32'(rdy_dly + 1));
        chk("wb_count", 32'(wb_count), 32'(ld));
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_areset_n = 1'b0;
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        i_funct3 = 3'b000; i_addr = 32'h0; i_wdata = 32'h0; i_rd = 5'd0;
        i_req_ready = 1'b0; i_data_valid = 1'b0; i_data = 32'h0;
        exp_addr = 0; exp_sdata = 0; exp_strb = 0; exp_write = 0;
        exp_wb = 0; exp_rd = 0; exp_trap = 0;
        req_cycles = 0; wb_count = 0;
        last_req_addr = 0; last_req_data = 0; last_req_strb = 0; last_wb_data = 0;

        #12;
        chk("rst_flags", {26'd0, o_stall, o_req, o_req_write, o_wb_valid, o_misalign, 1'b0}, 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_store_data", o_store_data, 32'd0);
        chk("rst_wstrb", 32'(o_wstrb), 32'd0);
        chk("rst_wb", o_wb_data, 32'd0);
        chk("rst_wb_rd", 32'(o_wb_rd), 32'd0);
        i_areset_n = 1'b1;
        @(posedge i_clk); #1;

        // Valid without a memory op is ignored
        i_valid = 1'b1;
        @(negedge i_clk);
        chk("nop_stall", 32'(o_stall), 32'd0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("nop_no_req", 32'(o_req), 32'd0);
        @(posedge i_clk); #1;

        // LW, immediate ready and response
        do_op(1'b1, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 5'd5, 0, 0);
        chk("lw_lit_addr", last_req_addr, 32'h0000_1000);
        chk("lw_lit_data", last_wb_data, 32'hDEAD_BEEF);

        // LB / LBU at offset 3
        do_op(1'b1, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 5'd6, 0, 0);
        chk("lb_lit", last_wb_data, 32'hFFFF_FF80);
        do_op(1'b1, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 5'd7, 0, 1);
        chk("lbu_lit", last_wb_data, 32'h0000_0080);

        // SH at offset 2
        do_op(1'b0, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 5'd0, 0, 0);
        chk("sh_lit_addr", last_req_addr, 32'h0000_2000);
        chk("sh_lit_strb", 32'(last_req_strb), 32'h0000_000C);
        chk("sh_lit_data", last_req_data, 32'hABCD_ABCD);

        // Ready held low for 5 cycles
        do_op(1'b1, 3'b010, 32'h0000_1004, 32'h0, 32'h1234_5678, 5'd8, 5, 2);

        // Halfword loads, signed/unsigned, upper lane
        do_op(1'b1, 3'b001, 32'h0000_1006, 32'h0, 32'h8001_7FFF, 5'd9, 1, 0);
        chk("lh_lit", last_wb_data, 32'hFFFF_8001);
        do_op(1'b1, 3'b101, 32'h0000_1006, 32'h0, 32'h8001_7FFF, 5'd10, 0, 0);
        chk("lhu_lit", last_wb_data, 32'h0000_8001);

        // SB at offset 1, SW, unsupported funct3 treated as a word
        do_op(1'b0, 3'b000, 32'h0000_2001, 32'h1234_5678, 32'h0, 5'd0, 0, 0);
        chk("sb_lit_strb", 32'(last_req_strb), 32'h0000_0002);
        chk("sb_lit_data", last_req_data, 32'h7878_7878);
        do_op(1'b0, 3'b010, 32'h0000_2004, 32'hCAFE_BABE, 32'h0, 5'd0, 2, 0);
        do_op(1'b1, 3'b011, 32'h0000_1008, 32'h0, 32'h8765_4321, 5'd11, 0, 0);
        chk("f3_011_lit", last_wb_data, 32'h8765_4321);

        // Misaligned LW
        do_op(1'b1, 3'b010, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 5'd12, 0, 0);
`ifndef MISALIGN_TRAP_EN
        chk("lw_mis_lit_addr", last_req_addr, 32'h0000_1000);
        chk("lw_mis_lit_data", last_wb_data, 32'hCAFE_F00D);
`endif

        // Reset while waiting in RESP
        set_model(1'b1, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 5'd13);
        i_valid = 1'b1; i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_3000; i_rd = 5'd13;
        i_req_ready = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_load = 1'b0;
        @(posedge i_clk); #1;
        i_req_ready = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_stall_before", 32'(o_stall), 32'd1);
        #1 i_areset_n = 1'b0;
        #1;
        chk("rst_mid_flags", {27'd0, o_stall, o_req, o_req_write, o_wb_valid, o_misalign}, 32'd0);
        chk("rst_mid_addr", o_addr, 32'd0);
        chk("rst_mid_wb", o_wb_data, 32'd0);
        chk("rst_mid_wb_rd", 32'(o_wb_rd), 32'd0);
        @(posedge i_clk); #2;
        i_areset_n = 1'b1;
        @(posedge i_clk); #1;
        do_op(1'b0, 3'b000, 32'h0000_4003, 32'h0000_00A5, 32'h0, 5'd0, 0, 0);
        chk("sb_after_rst_strb", 32'(last_req_strb), 32'h0000_0008);
        chk("sb_after_rst_data", last_req_data, 32'hA5A5_A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
